alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising-edge.
REQ-002 SHALL have: rst  in  1  asynchronous reset, active-high.
REQ-003 SHALL have: start  in  1  request, sampled in IDLE only.
REQ-004 SHALL have: op  in  3  opcode. 000 ADD, 001 SUB, 010 BUMPUP, 011 BUMPDN, 100 JUMPZ, 101 JUMPN, 110 COPYFROM, 111 COPYTO.
REQ-005 SHALL have: addr  in  5  memory tile address.
REQ-006 SHALL have: busy  out  1  high in every state except IDLE.
REQ-007 SHALL have: done  out  1  one-cycle completion pulse.
REQ-008 SHALL have: memAddr  out  5, memRd  out  1, memWr  out  1, memWrData  out  8, memRdData  in  8, memAck  in  1.
REQ-009 SHALL have: aluCtl  out  3, aluR  out  8 (ALU inR), aluM  out  8 (ALU inM), aluOut  in  8, flag  in  1.
REQ-010 SHALL have: R  out  8  accumulator (signed); branch  out  1  jump-taken result.

Function
REQ-011 ALU contract SHALL be: aluCtl[1:0] 00 inR+inM, 01 inR-inM, 10 inM+1, 11 inM-1; flag = zero(inR) when aluCtl[2]=0, negative(inR) when aluCtl[2]=1.
REQ-012 aluCtl SHALL be decoded from latched op: ADD 000, SUB 001, BUMPUP 010, BUMPDN 011, JUMPZ 000, JUMPN 100, others 000.
REQ-013 aluR SHALL equal R; aluM SHALL equal internal register M at all times.
REQ-014 States SHALL be IDLE, RD, EXEC, WR, DONE.
REQ-015 IDLE: on start=1 latch op and addr; JUMPZ/JUMPN -> EXEC; COPYTO -> WR with memWrData=R; all others -> RD.
REQ-016 start while busy SHALL be ignored; op/addr changes while busy SHALL have no effect.
REQ-017 RD: memRd=1, memAddr=latched addr; hold until memAck=1; on ack M<=memRdData, -> EXEC. No timeout.
REQ-018 EXEC (exactly 1 cycle): ADD/SUB R<=aluOut -> DONE; BUMPUP/BUMPDN R<=aluOut and write data<=aluOut -> WR; JUMPZ/JUMPN branch<=flag -> DONE; COPYFROM R<=M -> DONE.
REQ-019 WR: memWr=1, memAddr=latched addr, memWrData stable; hold until memAck=1, then -> DONE.
REQ-020 memRd and memWr SHALL never be high simultaneously; both low in IDLE, EXEC, DONE.
REQ-021 memAck outside RD/WR SHALL be ignored.
REQ-022 DONE: done=1 for one cycle, -> IDLE; start in DONE cycle ignored.
REQ-023 Arithmetic SHALL be 8-bit two's complement wrap, no saturation, no overflow flag.
REQ-024 branch SHALL update only on JUMPZ/JUMPN EXEC; hold otherwise.
REQ-025 Latency with memAck in first RD cycle: done asserted 3 cycles after start edge for ADD/SUB/COPYFROM; 4 for BUMP; 2 for JUMP; 2 for COPYTO.
REQ-026 Each memAck wait cycle SHALL add exactly one cycle of latency.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, R=0, M=0, branch=0, done=0, busy=0, memRd=0, memWr=0, memWrData=0, memAddr=0.
REQ-028 Reset mid-RD/WR SHALL drop memRd/memWr immediately, without waiting for memAck; no partial R update.
REQ-029 First start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-030 COPYFROM M=-3 (R=-3), then ADD M=5 -> R=2, done 3 cycles after start; then SUB M=5 from R=-3 -> R=-8.
REQ-031 BUMPUP tile holding 127, memAck delayed 2 cycles in RD -> R=-128, memWrData=-128 (0x80) written to same addr, done at cycle 6.
REQ-032 R=0 JUMPZ -> branch=1, no memRd/memWr; R=-3 JUMPZ -> branch=0; R=-3 JUMPN -> branch=1; R=5 JUMPN -> branch=0.
REQ-033 COPYTO addr 7 with R=-8 -> one WR phase, memWrData=0xF8, memAddr=7, R unchanged.
REQ-034 start pulses during busy and during DONE -> ignored, exactly one done per accepted request.
REQ-035 rst asserted mid-RD waiting on memAck -> memRd low same time, all outputs at reset values, next ADD executes correctly from R=0.

Source files
------------

// File: rtl/alu_seq.sv
// Sequencer around an external 8-bit ALU and a handshaked tile memory:
// fetch operand M, execute one op against accumulator R, optionally write back.
module alu_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [4:0] addr,
  output logic       busy,
  output logic       done,
  output logic [4:0] memAddr,
  output logic       memRd,
  output logic       memWr,
  output logic [7:0] memWrData,
  input  logic [7:0] memRdData,
  input  logic       memAck,
  output logic [2:0] aluCtl,
  output logic [7:0] aluR,
  output logic [7:0] aluM,
  input  logic [7:0] aluOut,
  input  logic       flag,
  output logic [7:0] R,
  output logic       branch,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    EXEC = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD      = 3'b000;
  localparam logic [2:0] OP_SUB      = 3'b001;
  localparam logic [2:0] OP_BUMPUP   = 3'b010;
  localparam logic [2:0] OP_BUMPDN   = 3'b011;
  localparam logic [2:0] OP_JUMPZ    = 3'b100;
  localparam logic [2:0] OP_JUMPN    = 3'b101;
  localparam logic [2:0] OP_COPYFROM = 3'b110;
  localparam logic [2:0] OP_COPYTO   = 3'b111;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] r_q, r_d;
  logic [7:0] m_q, m_d;
  logic [7:0] wdata_q, wdata_d;
  logic       branch_q, branch_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 3'd0;
      addr_q   <= 5'd0;
      r_q      <= 8'd0;
      m_q      <= 8'd0;
      wdata_q  <= 8'd0;
      branch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      r_q      <= r_d;
      m_q      <= m_d;
      wdata_q  <= wdata_d;
      branch_q <= branch_d;
    end
  end

  // Handshake: memRd/memWr stay asserted, with address and write data held,
  // until memAck is seen on a rising edge; memAck in any other state is ignored.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    r_d      = r_q;
    m_d      = m_q;
    wdata_d  = wdata_q;
    branch_d = branch_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          addr_d = addr;
          case (op)
            OP_JUMPZ, OP_JUMPN: state_d = EXEC;
            OP_COPYTO: begin
              wdata_d = r_q;
              state_d = WR;
            end
            default: state_d = RD;
          endcase
        end
      end
      RD: begin
        if (memAck) begin
          m_d     = memRdData;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = DONE;
        case (op_q)
          OP_ADD, OP_SUB: r_d = aluOut;
          OP_BUMPUP, OP_BUMPDN: begin
            r_d     = aluOut;
            wdata_d = aluOut;
            state_d = WR;
          end
          OP_JUMPZ, OP_JUMPN: branch_d = flag;
          OP_COPYFROM: r_d = m_q;
          default: ;
        endcase
      end
      WR: begin
        if (memAck) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SUB:    aluCtl = 3'b001;
      OP_BUMPUP: aluCtl = 3'b010;
      OP_BUMPDN: aluCtl = 3'b011;
      OP_JUMPN:  aluCtl = 3'b100;
      default:   aluCtl = 3'b000;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign memRd     = (state_q == RD);
  assign memWr     = (state_q == WR);
  assign memAddr   = addr_q;
  assign memWrData = wdata_q;
  assign aluR      = r_q;
  assign aluM      = m_q;
  assign R         = r_q;
  assign branch    = branch_q;
  assign dbg_state = state_q;

endmodule
